// File: rtl/uop_sequencer_pkg.sv
// uop_sequencer_pkg
//   Shared definitions for the ECDSA curve point engine microprogram sequencer:
//   uop field bit positions, the opcode and exec encodings the sequencer has to
//   recognise, the FSM state type and small decode helpers.
//   No ports (package).
package uop_sequencer_pkg;

  localparam int OPCODE_W = 6;
  localparam int SEL_W    = 4;
  localparam int EXEC_W   = 2;

  // uop word layout: [19:14] opcode, [13:10] src_a, [9:6] src_b, [5:2] dst, [1:0] exec
  localparam int UOP_OPCODE_HI = 19;
  localparam int UOP_OPCODE_LO = 14;
  localparam int UOP_SRC_A_HI  = 13;
  localparam int UOP_SRC_A_LO  = 10;
  localparam int UOP_SRC_B_HI  = 9;
  localparam int UOP_SRC_B_LO  = 6;
  localparam int UOP_DST_HI    = 5;
  localparam int UOP_DST_LO    = 2;
  localparam int UOP_EXEC_HI   = 1;
  localparam int UOP_EXEC_LO   = 0;

  // One-hot opcode order {CMP,MOV,ADD,SUB,MUL,RDY}
  localparam logic [OPCODE_W-1:0] OPCODE_CMP = 6'b100000;
  localparam logic [OPCODE_W-1:0] OPCODE_RDY = 6'b000001;

  // exec field: 00 always, 01 only when the CMP flag is set, 1x never
  localparam logic [EXEC_W-1:0] UOP_EXEC_ALWAYS     = 2'b00;
  localparam logic [EXEC_W-1:0] UOP_EXEC_PZT1T2_0XX = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_t;

  // A uop is sent to the worker only when its opcode is a single worker
  // operation; RDY, zero and multi-hot opcodes all end the program.
  function automatic logic opcode_runnable(input logic [OPCODE_W-1:0] op);
    return $onehot(op) && (op != OPCODE_RDY);
  endfunction

  function automatic logic exec_enabled(input logic [EXEC_W-1:0] exec,
                                        input logic              cmp_flag);
    logic en;
    en = 1'b0;
    if (exec == UOP_EXEC_ALWAYS) begin
      en = 1'b1;
    end else if (exec == UOP_EXEC_PZT1T2_0XX) begin
      en = cmp_flag;
    end
    return en;
  endfunction

endpackage

// File: rtl/uop_sequencer.sv
// uop_sequencer
//   Microprogram sequencer for the ECDSA curve point engine. Walks a uop ROM
//   from address 0, decodes each uop, issues it to the modular-arithmetic
//   worker, applies conditional execution from the CMP flag and reports
//   completion when an RDY (or malformed) opcode is fetched. Running off the
//   end of the program space ends the run with err=1.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   ena          start pulse, accepted only while rdy=1
//   rdy          1 = idle / program finished
//   err          1 = last run ended on address overflow
//   uop_addr     ROM address
//   uop_data     ROM word, valid ROM_LAT cycles after uop_addr
//   wrk_ena      one-cycle issue pulse to the worker
//   wrk_opcode   one-hot opcode, held from issue until worker completion
//   wrk_src_a/b  operand selects, wrk_dst destination select (held likewise)
//   wrk_rdy      worker done; sampled only in WAIT, never in the issue cycle
//   wrk_cmp_eq   CMP result, sampled together with wrk_rdy after a CMP
//   fsm_state    current sequencer state (observation only)
//
// Handshake: wrk_ena is a single-cycle request with no backpressure. After
// the issue cycle the sequencer waits for wrk_rdy=1; the worker is expected
// to drop wrk_rdy on the clock edge where it sees wrk_ena and raise it again
// when the operation is finished, for as many cycles as it needs.
module uop_sequencer
  import uop_sequencer_pkg::*;
#(
  parameter int UOP_ADDR_W = 6,
  parameter int UOP_W      = 20,
  parameter int ROM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  output logic                  rdy,
  output logic                  err,
  output logic [UOP_ADDR_W-1:0] uop_addr,
  input  logic [UOP_W-1:0]      uop_data,
  output logic                  wrk_ena,
  output logic [OPCODE_W-1:0]   wrk_opcode,
  output logic [SEL_W-1:0]      wrk_src_a,
  output logic [SEL_W-1:0]      wrk_src_b,
  output logic [SEL_W-1:0]      wrk_dst,
  input  logic                  wrk_rdy,
  input  logic                  wrk_cmp_eq,
  output seq_state_t            fsm_state
);

  localparam logic [1:0]            FETCH_LAST = 2'(ROM_LAT - 1);
  localparam logic [UOP_ADDR_W-1:0] ADDR_LAST  = {UOP_ADDR_W{1'b1}};

  seq_state_t            state, state_nxt;
  logic [1:0]            fetch_cnt;
  logic                  cmp_flag;

  logic                  addr_clr, addr_inc, err_set, err_clr;
  logic                  cnt_inc, fields_load, flag_load;
  logic                  at_last;

  logic [OPCODE_W-1:0]   dec_opcode;
  logic [SEL_W-1:0]      dec_src_a, dec_src_b, dec_dst;
  logic [EXEC_W-1:0]     dec_exec;

  assign dec_opcode = uop_data[UOP_OPCODE_HI:UOP_OPCODE_LO];
  assign dec_src_a  = uop_data[UOP_SRC_A_HI:UOP_SRC_A_LO];
  assign dec_src_b  = uop_data[UOP_SRC_B_HI:UOP_SRC_B_LO];
  assign dec_dst    = uop_data[UOP_DST_HI:UOP_DST_LO];
  assign dec_exec   = uop_data[UOP_EXEC_HI:UOP_EXEC_LO];

  assign at_last   = (uop_addr == ADDR_LAST);
  assign rdy       = (state == ST_IDLE);
  assign wrk_ena   = (state == ST_ISSUE);
  assign fsm_state = state;

  always_comb begin
    state_nxt   = state;
    addr_clr    = 1'b0;
    addr_inc    = 1'b0;
    err_set     = 1'b0;
    err_clr     = 1'b0;
    cnt_inc     = 1'b0;
    fields_load = 1'b0;
    flag_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ena) begin
          addr_clr  = 1'b1;
          err_clr   = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fetch_cnt == FETCH_LAST) begin
          state_nxt = ST_DECODE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DECODE: begin
        fields_load = 1'b1;
        if (!opcode_runnable(dec_opcode)) begin
          state_nxt = ST_DONE;
        end else if (!exec_enabled(dec_exec, cmp_flag)) begin
          // A skipped uop still advances the address, so it can also overflow.
          if (at_last) begin
            err_set   = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            addr_inc  = 1'b1;
            state_nxt = ST_FETCH;
          end
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (wrk_rdy) begin
          flag_load = (wrk_opcode == OPCODE_CMP);
          if (at_last) begin
            err_set   = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            addr_inc  = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt  <= '0;
      uop_addr   <= '0;
      err        <= 1'b0;
      cmp_flag   <= 1'b0;
      wrk_opcode <= '0;
      wrk_src_a  <= '0;
      wrk_src_b  <= '0;
      wrk_dst    <= '0;
    end else begin
      // The counter restarts every time FETCH is left, so each fetch waits
      // exactly ROM_LAT cycles.
      if (cnt_inc) begin
        fetch_cnt <= fetch_cnt + 2'd1;
      end else begin
        fetch_cnt <= '0;
      end

      if (addr_clr) begin
        uop_addr <= '0;
      end else if (addr_inc) begin
        uop_addr <= uop_addr + 1'b1;
      end

      if (err_clr) begin
        err <= 1'b0;
      end else if (err_set) begin
        err <= 1'b1;
      end

      if (flag_load) begin
        cmp_flag <= wrk_cmp_eq;
      end

      if (fields_load) begin
        wrk_opcode <= dec_opcode;
        wrk_src_a  <= dec_src_a;
        wrk_src_b  <= dec_src_b;
        wrk_dst    <= dec_dst;
      end
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// tb_uop_sequencer
//   Bench for uop_sequencer: a synchronous ROM model, a worker model with a
//   programmable busy time (CMP answers src_a == src_b), an issue monitor
//   feeding a scoreboard, and a program-level reference model that walks the
//   ROM image to predict issued uops, err, final address and run length.
module tb_uop_sequencer;
  import uop_sequencer_pkg::*;

  localparam int ROM_LAT = 1;
  localparam int BUDGET  = 20000;

  localparam logic [5:0] OP_CMP = 6'b100000;
  localparam logic [5:0] OP_MOV = 6'b010000;
  localparam logic [5:0] OP_ADD = 6'b001000;
  localparam logic [5:0] OP_SUB = 6'b000100;
  localparam logic [5:0] OP_MUL = 6'b000010;
  localparam logic [5:0] OP_RDY = 6'b000001;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ena = 1'b0;
  logic        rdy, err, wrk_ena;
  logic [5:0]  uop_addr, wrk_opcode;
  logic [19:0] uop_data;
  logic [3:0]  wrk_src_a, wrk_src_b, wrk_dst;
  logic        wrk_rdy, wrk_cmp_eq;
  seq_state_t  fsm_state;

  uop_sequencer #(.UOP_ADDR_W(6), .UOP_W(20), .ROM_LAT(ROM_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rdy(rdy), .err(err),
    .uop_addr(uop_addr), .uop_data(uop_data), .wrk_ena(wrk_ena),
    .wrk_opcode(wrk_opcode), .wrk_src_a(wrk_src_a), .wrk_src_b(wrk_src_b),
    .wrk_dst(wrk_dst), .wrk_rdy(wrk_rdy), .wrk_cmp_eq(wrk_cmp_eq),
    .fsm_state(fsm_state)
  );

  // ROM model
  logic [19:0] rom [64];
  logic [19:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom[uop_addr];
    for (int i = ROM_LAT - 1; i > 0; i--) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign uop_data = rom_pipe[ROM_LAT-1];

  // worker model
  int   wrk_lat = 2;
  int   busy_cnt = 0;
  logic pend_eq = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      wrk_rdy    <= 1'b1;
      wrk_cmp_eq <= 1'b0;
      busy_cnt   <= 0;
    end else if (wrk_ena) begin
      wrk_rdy    <= 1'b0;
      busy_cnt   <= wrk_lat;
      pend_eq    <= (wrk_src_a == wrk_src_b);
      wrk_cmp_eq <= 1'($urandom_range(0, 1));
    end else if (busy_cnt != 0) begin
      if (busy_cnt == 1) begin
        wrk_rdy    <= 1'b1;
        wrk_cmp_eq <= pend_eq;
      end
      busy_cnt <= busy_cnt - 1;
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // issue monitor
  int          act_issues = 0;
  int          stable_err = 0;
  logic        watching   = 1'b0;
  logic [17:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      watching = 1'b0;
    end else if (wrk_ena) begin
      if (watching) stable_err++;
      act_issues++;
      if (exp_q.size() > 0)
        check("issue", {uop_addr, wrk_opcode, wrk_src_a, wrk_src_b, wrk_dst}, exp_q.pop_front());
      held     = {wrk_opcode, wrk_src_a, wrk_src_b, wrk_dst};
      watching = 1'b1;
    end else if (watching) begin
      if ({wrk_opcode, wrk_src_a, wrk_src_b, wrk_dst} != held) stable_err++;
      if (wrk_rdy) watching = 1'b0;
    end
  end

  // reference model: walks the ROM image at program level
  logic       model_flag = 1'b0;
  int         exp_issues;
  logic       exp_err;
  logic [5:0] exp_addr;
  int         exp_busy;

  task automatic model_run();
    int   addr;
    logic [19:0] w;
    logic [5:0]  op;
    logic        run;
    addr = 0; exp_issues = 0; exp_busy = 1; exp_err = 1'b0;
    forever begin
      w  = rom[addr];
      op = w[19:14];
      exp_busy += ROM_LAT + 1;
      if ($countones(op) != 1 || op == OP_RDY) break;
      run = (w[1:0] == 2'b00) || (w[1:0] == 2'b01 && model_flag);
      if (run) begin
        exp_q.push_back({6'(addr), w[19:2]});
        exp_issues++;
        exp_busy += wrk_lat + 2;
        if (op == OP_CMP) model_flag = (w[13:10] == w[9:6]);
      end
      if (addr == 63) begin
        exp_err = 1'b1;
        break;
      end
      addr++;
    end
    exp_addr = 6'(addr);
  endtask

  function automatic logic [19:0] mk(input logic [5:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] d,
                                     input logic [1:0] ex);
    return {op, a, b, d, ex};
  endfunction

  function automatic logic [5:0] rand_op(input bit allow_end);
    logic [5:0] one;
    int r;
    one = 6'd1;
    r = allow_end ? $urandom_range(0, 15) : $urandom_range(2, 15);
    if (r == 0) return ($urandom_range(0, 1) != 0) ? 6'b000000 : 6'b011000;
    if (r == 1) return OP_RDY;
    return one << $urandom_range(1, 5);
  endfunction

  function automatic logic [19:0] rand_word(input bit allow_end, input bit rand_exec);
    logic [3:0] a, b;
    a = 4'($urandom_range(0, 15));
    b = ($urandom_range(0, 1) != 0) ? a : 4'($urandom_range(0, 15));
    return mk(rand_op(allow_end), a, b, 4'($urandom_range(0, 15)),
              rand_exec ? 2'($urandom_range(0, 3)) : 2'b00);
  endfunction

  // driver tasks
  task automatic start_run();
    act_issues = 0;
    stable_err = 0;
    model_run();
    @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
  endtask

  task automatic finish_run(input string name, input int pre);
    int cyc;
    cyc = pre;
    while (rdy == 1'b0 && cyc < BUDGET) begin
      cyc++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, cyc, exp_busy);
    check({name, "_rdy"}, rdy, 1'b1);
    check({name, "_err"}, err, exp_err);
    check({name, "_addr"}, uop_addr, exp_addr);
    check({name, "_issues"}, act_issues, exp_issues);
    check({name, "_field_hold"}, stable_err, 0);
    check({name, "_wrk_ena_idle"}, wrk_ena, 1'b0);
    check({name, "_exp_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = mk(OP_RDY, 4'd0, 4'd0, 4'd0, 2'b00);
  endtask

  initial begin
    int k;
    clear_rom();
    repeat (3) @(negedge clk);
    check("reset_rdy", rdy, 1'b1);
    check("reset_err", err, 1'b0);
    check("reset_wrk_ena", wrk_ena, 1'b0);
    check("reset_addr", uop_addr, 6'd0);
    check("reset_opcode", wrk_opcode, 6'd0);
    #2 rst_n = 1'b1;

    // MOV, ADD, RDY with a two-cycle worker
    rom[0] = mk(OP_MOV, 4'd3, 4'd5, 4'd7, 2'b00);
    rom[1] = mk(OP_ADD, 4'd9, 4'd2, 4'd4, 2'b00);
    rom[2] = mk(OP_RDY, 4'd0, 4'd0, 4'd0, 2'b00);
    wrk_lat = 2;
    start_run();
    finish_run("basic", 0);

    // CMP equal enables three conditional uops, CMP unequal suppresses them
    rom[0] = mk(OP_CMP, 4'd6, 4'd6, 4'd0, 2'b00);
    rom[1] = mk(OP_MOV, 4'd1, 4'd2, 4'd3, 2'b01);
    rom[2] = mk(OP_ADD, 4'd4, 4'd5, 4'd6, 2'b01);
    rom[3] = mk(OP_SUB, 4'd7, 4'd8, 4'd9, 2'b01);
    rom[4] = mk(OP_RDY, 4'd0, 4'd0, 4'd0, 2'b00);
    start_run();
    finish_run("cond_eq", 0);
    rom[0] = mk(OP_CMP, 4'd6, 4'd2, 4'd0, 2'b00);
    start_run();
    finish_run("cond_ne", 0);

    // long multiply
    rom[0] = mk(OP_MUL, 4'd10, 4'd11, 4'd12, 2'b00);
    rom[1] = mk(OP_RDY, 4'd0, 4'd0, 4'd0, 2'b00);
    wrk_lat = 300;
    start_run();
    finish_run("long_mul", 0);

    // no RDY anywhere: overflow at the last address
    for (int i = 0; i < 64; i++) rom[i] = rand_word(1'b0, 1'b0);
    wrk_lat = 1;
    start_run();
    finish_run("overflow", 0);

    // reset while waiting on the worker at address 9
    for (int i = 0; i < 12; i++) rom[i] = mk(OP_MOV, 4'(i), 4'd1, 4'd2, 2'b00);
    rom[12] = mk(OP_RDY, 4'd0, 4'd0, 4'd0, 2'b00);
    wrk_lat = 5;
    start_run();
    k = 0;
    while (!(wrk_ena && uop_addr == 6'd9) && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach_addr9", k < BUDGET, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_rdy", rdy, 1'b1);
    check("rst_wrk_ena", wrk_ena, 1'b0);
    check("rst_addr", uop_addr, 6'd0);
    check("rst_err", err, 1'b0);
    exp_q.delete();
    model_flag = 1'b0;
    #2 rst_n = 1'b1;

    // ena while busy is ignored; next run starts at address 0
    rom[0] = mk(OP_ADD, 4'd1, 4'd2, 4'd3, 2'b00);
    rom[1] = mk(OP_SUB, 4'd4, 4'd5, 4'd6, 2'b00);
    rom[2] = mk(OP_RDY, 4'd0, 4'd0, 4'd0, 2'b00);
    wrk_lat = 3;
    start_run();
    repeat (3) @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    finish_run("ena_busy", 4);
    start_run();
    finish_run("ena_rerun", 0);

    // random programs
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 64; i++) rom[i] = rand_word(1'b1, 1'b1);
      wrk_lat = $urandom_range(1, 4);
      start_run();
      finish_run($sformatf("rand%0d", r), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
